// File: rtl/ctrl_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_cmd_arbiter
// Purpose  : Schedules the single DDR4 command bus between the refresh,
//            precharge, activate and CAS requesters. Tracks open/closed state
//            of all 16 banks ({bg, ba}), enforces tRCD / tRP / tRRD / tCCD /
//            tRFC spacing and drains open banks itself before a refresh.
// Ports    : CK_t, reset              - clock, synchronous active-high reset
//            ref_req                  - refresh request (held until ref_gnt)
//            pre_req, pre_bank        - precharge request + bank
//            act_req, act_bank, act_row - activate request + bank + row
//            cas_req, cas_rw, cas_bank, cas_col - RD/WR request
//            ref_gnt/pre_gnt/act_gnt/cas_gnt - one-cycle grant pulses
//            cmd_valid, cmd_code, cmd_bank, cmd_addr - registered command
//            bank_open                - per-bank open flags
//            proto_err                - pulse on ACT-to-open / CAS-to-closed
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_cmd_arbiter #(
  parameter int T_RCD = 14,
  parameter int T_RP  = 14,
  parameter int T_RRD = 4,
  parameter int T_CCD = 4,
  parameter int T_RFC = 260
) (
  input  logic        CK_t,
  input  logic        reset,
  input  logic        ref_req,
  input  logic        pre_req,
  input  logic [3:0]  pre_bank,
  input  logic        act_req,
  input  logic [3:0]  act_bank,
  input  logic [14:0] act_row,
  input  logic        cas_req,
  input  logic        cas_rw,
  input  logic [3:0]  cas_bank,
  input  logic [9:0]  cas_col,
  output logic        ref_gnt,
  output logic        pre_gnt,
  output logic        act_gnt,
  output logic        cas_gnt,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic [3:0]  cmd_bank,
  output logic [14:0] cmd_addr,
  output logic [15:0] bank_open,
  output logic        proto_err
);

  localparam logic [1:0] ARB_RUN      = 2'd0;
  localparam logic [1:0] ARB_DRAIN    = 2'd1;
  localparam logic [1:0] ARB_REF_WAIT = 2'd2;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Timers are loaded with T-1 on the edge that registers the command, so a
  // timer reading 0 in cycle N+T-1 lets the follow-up command register and
  // appear on the bus exactly at cycle N+T.
  localparam logic [8:0] RCD_LD = (T_RCD > 0) ? 9'(T_RCD - 1) : 9'd0;
  localparam logic [8:0] RP_LD  = (T_RP  > 0) ? 9'(T_RP  - 1) : 9'd0;
  localparam logic [8:0] RRD_LD = (T_RRD > 0) ? 9'(T_RRD - 1) : 9'd0;
  localparam logic [8:0] CCD_LD = (T_CCD > 0) ? 9'(T_CCD - 1) : 9'd0;
  localparam logic [8:0] RFC_LD = (T_RFC > 0) ? 9'(T_RFC - 1) : 9'd0;

  logic [1:0]  r_state, w_next_state;
  logic [8:0]  r_rrd, r_ccd, r_rfc;
  logic [15:0] w_rcd_busy, w_rp_busy;

  // Next-cycle command produced by the arbitration logic
  logic        w_cmd_valid;
  logic [2:0]  w_cmd_code;
  logic [3:0]  w_cmd_bank;
  logic [14:0] w_cmd_addr;
  logic        w_ref_gnt, w_pre_gnt, w_act_gnt, w_cas_gnt, w_proto_err;

  logic        w_active;
  logic        w_pre_ok, w_act_ok, w_cas_ok;
  logic        w_act_open, w_cas_open;
  logic        w_any_open, w_drain_ref;
  logic [3:0]  w_drain_bank;

  // --------------------------------------------------------------------------
  // Per-bank tRCD / tRP timers
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 16; b++) begin : g_bank
    logic [8:0] r_rcd;
    logic [8:0] r_rp;

    always_ff @(posedge CK_t) begin
      if (reset) begin
        r_rcd <= 9'd0;
        r_rp  <= 9'd0;
      end else begin
        if (w_cmd_valid && w_cmd_code == CMD_ACT && w_cmd_bank == 4'(b))
          r_rcd <= RCD_LD;
        else if (r_rcd != 9'd0)
          r_rcd <= r_rcd - 9'd1;

        if (w_cmd_valid && w_cmd_code == CMD_PRE && w_cmd_bank == 4'(b))
          r_rp <= RP_LD;
        else if (r_rp != 9'd0)
          r_rp <= r_rp - 9'd1;
      end
    end

    assign w_rcd_busy[b] = (r_rcd != 9'd0);
    assign w_rp_busy[b]  = (r_rp != 9'd0);
  end

  // --------------------------------------------------------------------------
  // Request eligibility. A request is ignored in the cycle its grant is
  // visible, since the requester has not yet had a chance to drop it.
  // Illegal ACT/CAS are answered immediately (no timing wait) because they
  // never reach the bus.
  // --------------------------------------------------------------------------
  assign w_act_open = bank_open[act_bank];
  assign w_cas_open = bank_open[cas_bank];

  assign w_pre_ok = pre_req && !pre_gnt;
  assign w_act_ok = act_req && !act_gnt &&
                    (w_act_open || (r_rrd == 9'd0 && !w_rp_busy[act_bank]));
  assign w_cas_ok = cas_req && !cas_gnt &&
                    (!w_cas_open || (r_ccd == 9'd0 && !w_rcd_busy[cas_bank]));

  // Normal arbitration also runs in the last cycle of the tRFC wait so the
  // first post-refresh command lands exactly tRFC after the REF.
  assign w_active = (r_state == ARB_RUN) ||
                    (r_state == ARB_REF_WAIT && r_rfc == 9'd0);

  assign w_any_open  = |bank_open;
  // A requested PRE to an already closed bank still goes ahead of the REF,
  // because it restarts that bank's tRP.
  assign w_drain_ref = !w_any_open && !w_pre_ok && !(|w_rp_busy);

  always_comb begin
    w_drain_bank = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (bank_open[i]) w_drain_bank = 4'(i);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CK_t) begin
    if (reset) r_state <= ARB_RUN;
    else       r_state <= w_next_state;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_RUN: begin
        if (ref_req) w_next_state = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!w_any_open && w_drain_ref) w_next_state = ARB_REF_WAIT;
      end
      ARB_REF_WAIT: begin
        if (r_rfc == 9'd0) w_next_state = ref_req ? ARB_DRAIN : ARB_RUN;
      end
      default: w_next_state = ARB_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output (arbitration) logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_cmd_valid = 1'b0;
    w_cmd_code  = CMD_NOP;
    w_cmd_bank  = 4'd0;
    w_cmd_addr  = 15'd0;
    w_ref_gnt   = 1'b0;
    w_pre_gnt   = 1'b0;
    w_act_gnt   = 1'b0;
    w_cas_gnt   = 1'b0;
    w_proto_err = 1'b0;

    if (r_state == ARB_DRAIN) begin
      if (w_any_open) begin
        // Internal drain PRE; an external PRE to the same bank rides along.
        w_cmd_valid = 1'b1;
        w_cmd_code  = CMD_PRE;
        w_cmd_bank  = w_drain_bank;
        w_pre_gnt   = w_pre_ok && (pre_bank == w_drain_bank);
      end else if (w_pre_ok) begin
        w_cmd_valid = 1'b1;
        w_cmd_code  = CMD_PRE;
        w_cmd_bank  = pre_bank;
        w_pre_gnt   = 1'b1;
      end else if (w_drain_ref) begin
        w_cmd_valid = 1'b1;
        w_cmd_code  = CMD_REF;
        w_ref_gnt   = 1'b1;
      end
    end else if (w_active) begin
      // A pending refresh freezes ACT/CAS from the cycle it is seen.
      if (w_pre_ok) begin
        w_cmd_valid = 1'b1;
        w_cmd_code  = CMD_PRE;
        w_cmd_bank  = pre_bank;
        w_pre_gnt   = 1'b1;
      end else if (!ref_req && w_act_ok) begin
        w_act_gnt = 1'b1;
        if (w_act_open) begin
          w_proto_err = 1'b1;
        end else begin
          w_cmd_valid = 1'b1;
          w_cmd_code  = CMD_ACT;
          w_cmd_bank  = act_bank;
          w_cmd_addr  = act_row;
        end
      end else if (!ref_req && w_cas_ok) begin
        w_cas_gnt = 1'b1;
        if (!w_cas_open) begin
          w_proto_err = 1'b1;
        end else begin
          w_cmd_valid = 1'b1;
          w_cmd_code  = cas_rw ? CMD_WR : CMD_RD;
          w_cmd_bank  = cas_bank;
          w_cmd_addr  = {5'b0, cas_col};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered command/grant outputs, bank state and global timers
  // --------------------------------------------------------------------------
  always_ff @(posedge CK_t) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NOP;
      cmd_bank  <= 4'd0;
      cmd_addr  <= 15'd0;
      ref_gnt   <= 1'b0;
      pre_gnt   <= 1'b0;
      act_gnt   <= 1'b0;
      cas_gnt   <= 1'b0;
      proto_err <= 1'b0;
      bank_open <= 16'd0;
      r_rrd     <= 9'd0;
      r_ccd     <= 9'd0;
      r_rfc     <= 9'd0;
    end else begin
      cmd_valid <= w_cmd_valid;
      cmd_code  <= w_cmd_code;
      cmd_bank  <= w_cmd_bank;
      cmd_addr  <= w_cmd_addr;
      ref_gnt   <= w_ref_gnt;
      pre_gnt   <= w_pre_gnt;
      act_gnt   <= w_act_gnt;
      cas_gnt   <= w_cas_gnt;
      proto_err <= w_proto_err;

      if (w_cmd_valid && w_cmd_code == CMD_ACT)
        bank_open[w_cmd_bank] <= 1'b1;
      else if (w_cmd_valid && w_cmd_code == CMD_PRE)
        bank_open[w_cmd_bank] <= 1'b0;

      if (w_cmd_valid && w_cmd_code == CMD_ACT) r_rrd <= RRD_LD;
      else if (r_rrd != 9'd0)                   r_rrd <= r_rrd - 9'd1;

      if (w_cmd_valid && (w_cmd_code == CMD_RD || w_cmd_code == CMD_WR))
        r_ccd <= CCD_LD;
      else if (r_ccd != 9'd0)
        r_ccd <= r_ccd - 9'd1;

      if (w_cmd_valid && w_cmd_code == CMD_REF) r_rfc <= RFC_LD;
      else if (r_rfc != 9'd0)                   r_rfc <= r_rfc - 9'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_cmd_arbiter
// Purpose  : Directed self-checking bench for ctrl_cmd_arbiter. Inputs change
//            1 time unit after the rising edge; outputs are read at the same
//            point, well away from the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_cmd_arbiter;

  logic        CK_t = 1'b0;
  logic        reset;
  logic        ref_req, pre_req, act_req, cas_req, cas_rw;
  logic [3:0]  pre_bank, act_bank, cas_bank;
  logic [14:0] act_row;
  logic [9:0]  cas_col;
  logic        ref_gnt, pre_gnt, act_gnt, cas_gnt, cmd_valid, proto_err;
  logic [2:0]  cmd_code;
  logic [3:0]  cmd_bank;
  logic [14:0] cmd_addr;
  logic [15:0] bank_open;

  int checks   = 0;
  int failures = 0;

  ctrl_cmd_arbiter dut (
    .CK_t      (CK_t),
    .reset     (reset),
    .ref_req   (ref_req),
    .pre_req   (pre_req),
    .pre_bank  (pre_bank),
    .act_req   (act_req),
    .act_bank  (act_bank),
    .act_row   (act_row),
    .cas_req   (cas_req),
    .cas_rw    (cas_rw),
    .cas_bank  (cas_bank),
    .cas_col   (cas_col),
    .ref_gnt   (ref_gnt),
    .pre_gnt   (pre_gnt),
    .act_gnt   (act_gnt),
    .cas_gnt   (cas_gnt),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr),
    .bank_open (bank_open),
    .proto_err (proto_err)
  );

  always #5 CK_t = ~CK_t;

  task automatic step();
    @(posedge CK_t);
    #1;
  endtask

  // Steps until a command is on the bus; n = cycles waited, -1 on timeout.
  task automatic wait_cmd(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cmd_valid && n < max);
    if (!cmd_valid) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ref_req = 0; pre_req = 0; act_req = 0; cas_req = 0; cas_rw = 0;
    pre_bank = 0; act_bank = 0; cas_bank = 0; act_row = 0; cas_col = 0;
    step();
    step();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || cmd_addr !== 15'd0 || cmd_bank !== 4'd0) begin
      failures++;
      $display("FAIL reset_cmd: valid=%b code=%0d addr=%h bank=%0d, required 0/0/0/0",
               cmd_valid, cmd_code, cmd_addr, cmd_bank);
    end
    checks++;
    if ({ref_gnt, pre_gnt, act_gnt, cas_gnt, proto_err} !== 5'b0 || bank_open !== 16'h0) begin
      failures++;
      $display("FAIL reset_flags: gnts/err=%b bank_open=%h, required 0", 
               {ref_gnt, pre_gnt, act_gnt, cas_gnt, proto_err}, bank_open);
    end
  endtask

  task automatic test_act_then_cas();
    int n;
    reset = 1'b0;
    act_req = 1; act_bank = 4'd3; act_row = 15'h1234;
    step();
    checks++;
    if (!(cmd_valid === 1'b1 && cmd_code === 3'd1 && act_gnt === 1'b1)) begin
      failures++;
      $display("FAIL act_issue: valid=%b code=%0d gnt=%b, required 1/1/1", cmd_valid, cmd_code, act_gnt);
    end
    checks++;
    if (cmd_addr !== 15'h1234 || cmd_bank !== 4'd3 || bank_open !== 16'h0008) begin
      failures++;
      $display("FAIL act_fields: addr=%h bank=%0d open=%h, required 1234/3/0008", cmd_addr, cmd_bank, bank_open);
    end
    act_req = 0;
    cas_req = 1; cas_rw = 0; cas_bank = 4'd3; cas_col = 10'h055;
    wait_cmd(40, n);
    checks++;
    if (n !== 14) begin
      failures++;
      $display("FAIL trcd_latency: got %0d cycles, required 14", n);
    end
    checks++;
    if (cmd_code !== 3'd2 || cmd_addr !== 15'h0055 || cas_gnt !== 1'b1 || cmd_bank !== 4'd3) begin
      failures++;
      $display("FAIL cas_rd_fields: code=%0d addr=%h gnt=%b bank=%0d, required 2/0055/1/3",
               cmd_code, cmd_addr, cas_gnt, cmd_bank);
    end
    cas_req = 0;
  endtask

  task automatic test_back_to_back();
    int n;
    act_req = 1; act_bank = 4'd0; act_row = 15'h0100;
    step();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd1 || cmd_bank !== 4'd0) begin
      failures++;
      $display("FAIL b2b_act0: valid=%b code=%0d bank=%0d, required 1/1/0", cmd_valid, cmd_code, cmd_bank);
    end
    act_bank = 4'd5; act_row = 15'h0200;
    wait_cmd(20, n);
    checks++;
    if (n !== 4 || cmd_code !== 3'd1 || cmd_bank !== 4'd5) begin
      failures++;
      $display("FAIL trrd_spacing: n=%0d code=%0d bank=%0d, required 4/1/5", n, cmd_code, cmd_bank);
    end
    act_req = 0;
    cas_req = 1; cas_rw = 1; cas_bank = 4'd0; cas_col = 10'h3FF;
    wait_cmd(40, n);
    checks++;
    if (n !== 10 || cmd_code !== 3'd3 || cmd_bank !== 4'd0 || cmd_addr !== 15'h03FF) begin
      failures++;
      $display("FAIL cas_wr0: n=%0d code=%0d bank=%0d addr=%h, required 10/3/0/03ff",
               n, cmd_code, cmd_bank, cmd_addr);
    end
    cas_bank = 4'd5;
    wait_cmd(20, n);
    checks++;
    if (n !== 4 || cmd_code !== 3'd3 || cmd_bank !== 4'd5) begin
      failures++;
      $display("FAIL tccd_spacing: n=%0d code=%0d bank=%0d, required 4/3/5", n, cmd_code, cmd_bank);
    end
    cas_req = 0;
  endtask

  task automatic test_pre_then_act();
    int n1, n2;
    act_req = 1; act_bank = 4'd2; act_row = 15'h0022;
    wait_cmd(20, n1);
    pre_req = 1; pre_bank = 4'd2;
    step();
    checks++;
    if (cmd_code !== 3'd4 || pre_gnt !== 1'b1 || cmd_bank !== 4'd2 || bank_open[2] !== 1'b0) begin
      failures++;
      $display("FAIL pre_issue: code=%0d gnt=%b bank=%0d open2=%b, required 4/1/2/0",
               cmd_code, pre_gnt, cmd_bank, bank_open[2]);
    end
    pre_req = 0;
    act_bank = 4'd7; act_row = 15'h0777;
    wait_cmd(20, n1);
    checks++;
    if (n1 !== 3 || cmd_code !== 3'd1 || cmd_bank !== 4'd7) begin
      failures++;
      $display("FAIL act7_in_trp_window: n=%0d code=%0d bank=%0d, required 3/1/7", n1, cmd_code, cmd_bank);
    end
    act_bank = 4'd2; act_row = 15'h0222;
    wait_cmd(30, n2);
    checks++;
    if (n1 + n2 !== 14 || cmd_code !== 3'd1 || cmd_bank !== 4'd2 || cmd_addr !== 15'h0222) begin
      failures++;
      $display("FAIL trp_latency: n=%0d code=%0d bank=%0d addr=%h, required 14/1/2/0222",
               n1 + n2, cmd_code, cmd_bank, cmd_addr);
    end
    act_req = 0;
  endtask

  task automatic test_refresh_drain();
    int n;
    reset = 1; step(); reset = 0;
    act_req = 1; act_bank = 4'd1; act_row = 15'h0011;
    wait_cmd(5, n);
    act_bank = 4'd9; act_row = 15'h0099;
    wait_cmd(10, n);
    checks++;
    if (bank_open !== 16'h0202) begin
      failures++;
      $display("FAIL drain_setup: bank_open=%h, required 0202", bank_open);
    end
    ref_req = 1;
    act_bank = 4'd12; act_row = 15'h0ccc;
    wait_cmd(10, n);
    checks++;
    if (n !== 2 || cmd_code !== 3'd4 || cmd_bank !== 4'd1 || pre_gnt !== 1'b0) begin
      failures++;
      $display("FAIL drain_pre1: n=%0d code=%0d bank=%0d gnt=%b, required 2/4/1/0", n, cmd_code, cmd_bank, pre_gnt);
    end
    wait_cmd(10, n);
    checks++;
    if (n !== 1 || cmd_code !== 3'd4 || cmd_bank !== 4'd9 || bank_open !== 16'h0) begin
      failures++;
      $display("FAIL drain_pre9: n=%0d code=%0d bank=%0d open=%h, required 1/4/9/0000",
               n, cmd_code, cmd_bank, bank_open);
    end
    wait_cmd(30, n);
    checks++;
    if (n !== 14 || cmd_code !== 3'd5 || ref_gnt !== 1'b1) begin
      failures++;
      $display("FAIL ref_issue: n=%0d code=%0d gnt=%b, required 14/5/1", n, cmd_code, ref_gnt);
    end
    ref_req = 0;
    wait_cmd(400, n);
    checks++;
    if (n !== 260 || cmd_code !== 3'd1 || cmd_bank !== 4'd12 || act_gnt !== 1'b1) begin
      failures++;
      $display("FAIL trfc_then_act: n=%0d code=%0d bank=%0d gnt=%b, required 260/1/12/1",
               n, cmd_code, cmd_bank, act_gnt);
    end
  endtask

  task automatic test_proto_err();
    int n;
    act_bank = 4'd4; act_row = 15'h0044;
    wait_cmd(10, n);
    checks++;
    if (cmd_code !== 3'd1 || cmd_bank !== 4'd4 || bank_open !== 16'h1010) begin
      failures++;
      $display("FAIL act4_open: code=%0d bank=%0d open=%h, required 1/4/1010", cmd_code, cmd_bank, bank_open);
    end
    step();
    step();
    checks++;
    if (act_gnt !== 1'b1 || proto_err !== 1'b1 || cmd_valid !== 1'b0 || bank_open !== 16'h1010) begin
      failures++;
      $display("FAIL act_open_err: gnt=%b err=%b valid=%b open=%h, required 1/1/0/1010",
               act_gnt, proto_err, cmd_valid, bank_open);
    end
    act_req = 0;
    cas_req = 1; cas_rw = 0; cas_bank = 4'd6; cas_col = 10'h006;
    step();
    checks++;
    if (cas_gnt !== 1'b1 || proto_err !== 1'b1 || cmd_valid !== 1'b0 || bank_open !== 16'h1010) begin
      failures++;
      $display("FAIL cas_closed_err: gnt=%b err=%b valid=%b open=%h, required 1/1/0/1010",
               cas_gnt, proto_err, cmd_valid, bank_open);
    end
    cas_req = 0;
    step();
    checks++;
    if (proto_err !== 1'b0 || cas_gnt !== 1'b0) begin
      failures++;
      $display("FAIL err_single_pulse: err=%b gnt=%b, required 0/0", proto_err, cas_gnt);
    end
  endtask

  task automatic test_reset_mid_rfc();
    int n;
    ref_req = 1;
    do begin
      wait_cmd(40, n);
    end while (n > 0 && cmd_code !== 3'd5);
    checks++;
    if (n <= 0 || ref_gnt !== 1'b1) begin
      failures++;
      $display("FAIL ref_before_reset: n=%0d gnt=%b, required REF issued", n, ref_gnt);
    end
    ref_req = 0;
    repeat (100) step();
    reset = 1;
    step();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'd0 || bank_open !== 16'h0 ||
        {ref_gnt, pre_gnt, act_gnt, cas_gnt, proto_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_rfc: valid=%b code=%0d open=%h flags=%b, required all 0",
               cmd_valid, cmd_code, bank_open, {ref_gnt, pre_gnt, act_gnt, cas_gnt, proto_err});
    end
    reset = 0;
    act_req = 1; act_bank = 4'd8; act_row = 15'h0888;
    step();
    checks++;
    if (act_gnt !== 1'b1 || cmd_valid !== 1'b1 || cmd_code !== 3'd1 || cmd_bank !== 4'd8 || cmd_addr !== 15'h0888) begin
      failures++;
      $display("FAIL act_after_reset: gnt=%b valid=%b code=%0d bank=%0d addr=%h, required 1/1/1/8/0888",
               act_gnt, cmd_valid, cmd_code, cmd_bank, cmd_addr);
    end
    act_req = 0;
  endtask

  initial begin
    test_reset();
    test_act_then_cas();
    test_back_to_back();
    test_pre_then_act();
    test_refresh_drain();
    test_proto_err();
    test_reset_mid_rfc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
